// File: rtl/sqrt_seq_nr.sv
// Sequential non-restoring square root producing floor(sqrt(din << 2*FRAC_W)), one result bit per clock.
// Latency: out_valid rises OUT_W clocks after the accepting edge (OUT_W+1 when SQRT_REM_EN is defined).
// Backpressure: result is held in DONE until out_ready; in_ready is low from acceptance until DONE hands off.
// Optional macro SQRT_REM_EN adds the out_rem port and a remainder-correction (FIX) state.
module sqrt_seq_nr #(
  parameter int IN_W   = 8,
  parameter int FRAC_W = 8,
  localparam int RAD_W = IN_W + 2*FRAC_W,
  localparam int OUT_W = RAD_W/2,
  localparam int CNT_W = $clog2(OUT_W+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  din,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] dout,
  output logic             busy
`ifdef SQRT_REM_EN
  ,
  output logic [OUT_W+1:0] out_rem
`endif
);

  // Partial remainder is signed and needs two guard bits so the all-ones radicand cannot overflow.
  localparam int R_W = OUT_W + 2;

  generate
    if ((IN_W % 2) != 0) begin : g_bad_in_w
      $error("sqrt_seq_nr: IN_W must be even");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [RAD_W-1:0] r_rad;
  logic [OUT_W-1:0] r_q;
  logic [R_W-1:0]   r_r;
  logic [CNT_W-1:0] r_cnt;

  logic [R_W-1:0]   w_r_sh;
  logic [R_W-1:0]   w_r_nxt;
  logic             w_last;

  // Next radicand pair shifted into the remainder; the sign of r picks subtract or add.
  assign w_r_sh  = {r_r[R_W-3:0], r_rad[RAD_W-1 -: 2]};
  assign w_r_nxt = r_r[R_W-1] ? (w_r_sh + {r_q, 2'b11}) : (w_r_sh - {r_q, 2'b01});
  assign w_last  = (r_cnt == CNT_W'(1));

  assign dout = r_q;
`ifdef SQRT_REM_EN
  assign out_rem = r_r;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = rst_n;
        if (in_valid && rst_n) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        busy = 1'b1;
`ifdef SQRT_REM_EN
        if (w_last) w_state_nxt = S_FIX;
`else
        if (w_last) w_state_nxt = S_DONE;
`endif
      end
      S_FIX: begin
        busy        = 1'b1;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: load on accept, one root bit per BUSY cycle, optional remainder fix-up.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rad <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_rad <= RAD_W'(din) << (2*FRAC_W);
            r_q   <= '0;
            r_r   <= '0;
            r_cnt <= CNT_W'(OUT_W);
          end
        end
        S_BUSY: begin
          r_r   <= w_r_nxt;
          r_q   <= {r_q[OUT_W-2:0], ~w_r_nxt[R_W-1]};
          r_rad <= r_rad << 2;
          r_cnt <= r_cnt - CNT_W'(1);
        end
`ifdef SQRT_REM_EN
        S_FIX: begin
          if (r_r[R_W-1]) r_r <= r_r + {1'b0, r_q, 1'b1};
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
